// File: rtl/player_motion_unit.sv
// player_motion_unit
//   Integrates accelerometer samples into the on-screen player-box centre, once per
//   frame: acceleration -> velocity (with damping and a speed limit), then
//   velocity -> position (6 fractional bits). The result is clamped so the 50x50 box
//   stays fully visible, and it is published as integer pixel coordinates.
//
// Ports
//   clk_25mHz     in   1        pixel clock, all logic on posedge
//   reset         in   1        asynchronous, active-low reset
//   sample_valid  in   1        accel_raw_x/y valid this cycle
//   sample_ready  out  1        sample accepted this cycle (IDLE only)
//   accel_raw_x   in   ACCEL_W  signed x acceleration
//   accel_raw_y   in   ACCEL_W  signed y acceleration
//   frame_tick    in   1        one-cycle pulse per frame (VGA screenEnd)
//   run           in   1        1 = integrate, 0 = hold position with zero velocity
//   pos_x         out  32       player centre x, integer pixels
//   pos_y         out  32       player centre y, integer pixels
//   pos_updated   out  1        one-cycle pulse when pos_x/pos_y are written
//   missed_ticks  out  8        saturating count of frame ticks dropped while busy
//
// Build option
//   MOTION_DEADZONE_EN : when defined, an axis with |accel| < 16 is treated as 0.
//
// States
//   IDLE  | waiting for frame_tick, accepts samples
//   VEL   | velocity update from acceleration and damping
//   POS   | position += velocity
//   CLAMP | keep box on screen, zero velocity of a clamped axis
//   PUB   | publish integer position, pulse pos_updated

module player_motion_unit #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int HALF_SIZE   = 25,
  parameter int ACCEL_W     = 12,
  parameter int FRAC_BITS   = 6,
  parameter int ACCEL_SHIFT = 4,
  parameter int DAMP_SHIFT  = 3,
  parameter int VMAX        = 512
) (
  input  logic               clk_25mHz,
  input  logic               reset,
  input  logic               sample_valid,
  output logic               sample_ready,
  input  logic [ACCEL_W-1:0] accel_raw_x,
  input  logic [ACCEL_W-1:0] accel_raw_y,
  input  logic               frame_tick,
  input  logic               run,
  output logic [31:0]        pos_x,
  output logic [31:0]        pos_y,
  output logic               pos_updated,
  output logic [7:0]         missed_ticks
);

  localparam int VW  = 12;               // holds +/-VMAX with margin
  localparam int SW  = VW + 2;           // headroom for the velocity sum
  localparam int PW  = FRAC_BITS + 11;   // signed fixed-point position
  localparam int IW  = PW - FRAC_BITS;   // integer bits published

  localparam logic signed [PW-1:0] POS_LO   = PW'(HALF_SIZE << FRAC_BITS);
  localparam logic signed [PW-1:0] POS_HI_X = PW'((SCREEN_W - 1 - HALF_SIZE) << FRAC_BITS);
  localparam logic signed [PW-1:0] POS_HI_Y = PW'((SCREEN_H - 1 - HALF_SIZE) << FRAC_BITS);
  localparam logic signed [PW-1:0] POS_RST_X = PW'((SCREEN_W / 2) << FRAC_BITS);
  localparam logic signed [PW-1:0] POS_RST_Y = PW'((SCREEN_H / 2) << FRAC_BITS);

  typedef enum logic [2:0] {IDLE, VEL, POS, CLAMP, PUB} state_t;

  state_t                     state;
  logic signed [ACCEL_W-1:0]  lat_x, lat_y;   // newest accepted sample
  logic signed [ACCEL_W-1:0]  use_x, use_y;   // sample frozen at the tick for this frame
  logic signed [VW-1:0]       vel_x, vel_y;
  logic signed [PW-1:0]       pos_fp_x, pos_fp_y;

  function automatic logic signed [ACCEL_W-1:0] eff_accel(input logic signed [ACCEL_W-1:0] a);
`ifdef MOTION_DEADZONE_EN
    localparam int DEADZONE = 16;
    if (a > -DEADZONE && a < DEADZONE) return '0;
    else return a;
`else
    return a;
`endif
  endfunction

  function automatic logic signed [VW-1:0] vel_step(input logic signed [VW-1:0] v,
                                                    input logic signed [ACCEL_W-1:0] a);
    logic signed [SW-1:0] sum;
    sum = SW'(v) + SW'(a >>> ACCEL_SHIFT) - SW'(v >>> DAMP_SHIFT);
    if (sum > VMAX)       return VW'(VMAX);
    else if (sum < -VMAX) return VW'(-VMAX);
    else                  return VW'(sum);
  endfunction

  always_ff @(posedge clk_25mHz or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      sample_ready <= 1'b0;
      lat_x        <= '0;
      lat_y        <= '0;
      use_x        <= '0;
      use_y        <= '0;
      vel_x        <= '0;
      vel_y        <= '0;
      pos_fp_x     <= POS_RST_X;
      pos_fp_y     <= POS_RST_Y;
      pos_x        <= 32'(SCREEN_W / 2);
      pos_y        <= 32'(SCREEN_H / 2);
      pos_updated  <= 1'b0;
      missed_ticks <= '0;
    end else begin
      pos_updated <= 1'b0;
      if (frame_tick && state != IDLE && missed_ticks != 8'hFF)
        missed_ticks <= missed_ticks + 8'd1;

      case (state)
        IDLE: begin
          if (sample_valid && sample_ready) begin
            lat_x <= accel_raw_x;
            lat_y <= accel_raw_y;
          end
          // Freeze the pre-handshake latch so a same-cycle sample waits a frame.
          if (frame_tick) begin
            use_x        <= lat_x;
            use_y        <= lat_y;
            state        <= VEL;
            sample_ready <= 1'b0;
          end else begin
            sample_ready <= 1'b1;
          end
        end
        VEL: begin
          if (run) begin
            vel_x <= vel_step(vel_x, eff_accel(use_x));
            vel_y <= vel_step(vel_y, eff_accel(use_y));
          end else begin
            vel_x <= '0;
            vel_y <= '0;
          end
          state <= POS;
        end
        POS: begin
          pos_fp_x <= pos_fp_x + PW'(vel_x);
          pos_fp_y <= pos_fp_y + PW'(vel_y);
          state    <= CLAMP;
        end
        CLAMP: begin
          if (pos_fp_x < POS_LO) begin
            pos_fp_x <= POS_LO;
            vel_x    <= '0;
          end else if (pos_fp_x > POS_HI_X) begin
            pos_fp_x <= POS_HI_X;
            vel_x    <= '0;
          end
          if (pos_fp_y < POS_LO) begin
            pos_fp_y <= POS_LO;
            vel_y    <= '0;
          end else if (pos_fp_y > POS_HI_Y) begin
            pos_fp_y <= POS_HI_Y;
            vel_y    <= '0;
          end
          state <= PUB;
        end
        PUB: begin
          // Position is non-negative after clamping, so a plain bit slice suffices.
          pos_x        <= {{(32-IW){1'b0}}, pos_fp_x[PW-1:FRAC_BITS]};
          pos_y        <= {{(32-IW){1'b0}}, pos_fp_y[PW-1:FRAC_BITS]};
          pos_updated  <= 1'b1;
          state        <= IDLE;
          sample_ready <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          sample_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
